// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin grant of one shared mux4 path to four requesters; ARB_TIMEOUT_EN adds a MAX_HOLD forced release.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic req4,
  input  logic done,
  output logic gnt1,
  output logic gnt2,
  output logic gnt3,
  output logic gnt4,
  output logic sel1,
  output logic sel2,
  output logic busy,
  output logic expired
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, n_state;
  logic [3:0] r, gnt, n_gnt;
  logic [1:0] sel, n_sel, last, n_last, pick;
  logic n_exp, to;
  assign r = {req4, req3, req2, req1};
  assign {gnt4, gnt3, gnt2, gnt1} = gnt;
  assign {sel2, sel1} = sel;
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign to = cnt == 8'(MAX_HOLD - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (state == IDLE) ? 8'd0 : cnt + 8'd1;
`else
  logic unused_hold;
  assign unused_hold = ^8'(MAX_HOLD);
  assign to = 1'b0;
`endif
  // last-owner index is lowest priority; nearest following requester wins
  always_comb begin
    pick = last;
    for (int i = 4; i >= 1; i--)
      if (r[2'(last + 2'(i))]) pick = 2'(last + 2'(i));
    n_state = state;
    n_gnt = gnt;
    n_sel = sel;
    n_last = last;
    n_exp = 1'b0;
    if (state == IDLE) begin
      if (|r) begin
        n_state = GRANT;
        n_gnt = 4'b1 << pick;
        n_sel = pick;
        n_last = pick;
      end
    end else if (done || !r[sel] || to) begin
      n_state = IDLE;
      n_gnt = '0;
      n_exp = to && !done;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      last <= 2'd3;
      busy <= 1'b0;
      expired <= 1'b0;
    end else begin
      state <= n_state;
      gnt <= n_gnt;
      sel <= n_sel;
      last <= n_last;
      busy <= |n_gnt;
      expired <= n_exp;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one mux4 datapath among four requesters.
- Grants exactly one requester at a time and drives the mux4 select pair (sel1, sel2) so the mux routes the granted requester's input to the shared output.
- Sits beside a mux4 instance. Requesters raise a request, wait for their grant, use the shared path, then release with done or by dropping their request.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one requester may hold the grant. Legal range 1..255. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req1  input  1  request from requester 1 (mux in1)
- req2  input  1  request from requester 2 (mux in2)
- req3  input  1  request from requester 3 (mux in3)
- req4  input  1  request from requester 4 (mux in4)
- done  input  1  current owner releases the grant (ignored when no grant is active)
- gnt1  output  1  grant to requester 1
- gnt2  output  1  grant to requester 2
- gnt3  output  1  grant to requester 3
- gnt4  output  1  grant to requester 4
- sel1  output  1  mux4 select LSB
- sel2  output  1  mux4 select MSB
- busy  output  1  high while any grant is active
- expired  output  1  one-cycle pulse on forced release (constant 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, immediate, also mid-grant):
  - gnt1..gnt4 = 0, busy = 0, expired = 0, sel1 = sel2 = 0.
  - State = IDLE. Last-owner pointer = 4, so requester 1 has top priority first.
- Outputs: all registered; no combinational path from inputs to outputs.
- Select encoding follows mux4:
  - owner 1 -> sel2,sel1 = 00
  - owner 2 -> 01
  - owner 3 -> 10
  - owner 4 -> 11
- sel1/sel2 update on the same edge as the gnt bit. They hold their last value while IDLE.
- State IDLE:
  - If any reqN is sampled high, the next edge grants the first requester found scanning cyclically from (last+1), wrapping 4 -> 1.
  - On that edge: set gntN, busy = 1, update sel, last = N, go to GRANT.
  - Grant latency = 1 cycle from the sampled request.
  - No request: stay in IDLE, outputs unchanged.
- State GRANT:
  - gntN and sel are held stable.
  - Release condition: done = 1, or the owner's reqN = 0.
  - On release: next edge clears gntN and busy, goes to IDLE. sel holds.
- Dead cycle: exactly one IDLE cycle (all gnt = 0) between successive grants, even when other requests are pending. This guarantees a clean mux switch.
- Simultaneous done and owner req still high: release wins. That owner has lowest priority in the next arbitration.
- Requests from non-owners during GRANT: no effect until the next IDLE cycle.
- done in IDLE: ignored.
- Invariant: at most one gnt bit is high at any time. busy = OR(gnt1..gnt4).

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on each grant and increments every GRANT cycle.
  - When the counter reaches MAX_HOLD - 1 with no release, the next edge forces release exactly like done, and expired pulses for that one cycle (the first IDLE cycle).
  - If done arrives on the same cycle, the release is normal and expired stays 0.
  - Counter resets asynchronously with rst.
- Undefined:
  - No counter; the grant is held indefinitely until release; expired tied to 0.

Test Plan:
- Reset then req1 = 1 → one edge later gnt1 = 1, sel2,sel1 = 00, busy = 1. Then done = 1 → next edge gnt1 = 0, busy = 0.
- req1..req4 all held high, done pulsed each grant → grant order 1, 2, 3, 4, 1, each grant separated by one all-zero IDLE cycle; sel sequence 00, 01, 10, 11, 00.
- Owner 3 granted, req2 and req4 high, done and req3 high in same cycle → release; next grant goes to 4, then 2; sel holds 10 during the dead cycle.
- Owner 2 drops req2 without done → gnt2 clears next edge; req1 pending → gnt1 one dead cycle later.
- rst asserted mid-grant of owner 4 (asynchronously, between edges) → gnt4, busy, sel clear immediately. After rst deasserts with req1 and req4 high, gnt1 wins.
- ARB_TIMEOUT_EN, MAX_HOLD = 3, req2 held, done never asserted → gnt2 high for 3 cycles, then cleared with expired = 1 for one cycle, then regranted. Without the macro, gnt2 stays high for 20+ cycles and expired stays 0.
